// File: rtl/sr_iter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sr_iter_pkg
//  Description : Shared types and constants for the iterative right shifter.
//  Revision    : 1.0 - initial release
// ============================================================================
package sr_iter_pkg;

    localparam int c_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of the shift-amount field for a given operand width.
    function automatic int shamt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sr_step.sv
`default_nettype none
// ============================================================================
//  Module      : sr_step
//  Description : Combinational one-bit right shift with zero/sign fill select.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_data,
    input  logic         i_arith,
    output logic [N-1:0] o_data
);

    logic w_fill;

    assign w_fill = i_arith & i_data[N-1];
    assign o_data = {w_fill, i_data[N-1:1]};

endmodule
`default_nettype wire

// File: rtl/sr_iter.sv
`default_nettype none
// ============================================================================
//  Module      : sr_iter
//  Description : Iterative right shifter, one bit per clock, done pulse at end.
//                Define SR_ITER_ARITH_EN to honour the arith (sign-fill) input.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_iter
    import sr_iter_pkg::*;
#(
    parameter int N  = c_DEFAULT_WIDTH,
    parameter int SW = shamt_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  num,
    input  logic [SW-1:0] shamt,
    input  logic          arith,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  result
);

    state_t        state_q, state_d;
    logic [N-1:0]  shreg_q, shreg_d;
    logic [SW-1:0] cnt_q,   cnt_d;
    logic [N-1:0]  w_step;
    logic          w_fill_arith;

`ifdef SR_ITER_ARITH_EN
    logic arith_q, arith_d;

    always_ff @(posedge clk) begin
        if (rst) arith_q <= 1'b0;
        else     arith_q <= arith_d;
    end

    always_comb begin
        arith_d = arith_q;
        if (state_q == IDLE && start) arith_d = arith;
    end

    assign w_fill_arith = arith_q;
`else
    // Port kept for a uniform interface; every shift is logical in this build.
    logic w_unused_arith;
    assign w_unused_arith = arith;
    assign w_fill_arith   = 1'b0;
`endif

    sr_step #(.N(N)) u_step (
        .i_data  (shreg_q),
        .i_arith (w_fill_arith),
        .o_data  (w_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = num;
                    cnt_d   = shamt;
                    state_d = (shamt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                shreg_d = w_step;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == SW'(1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = shreg_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr_iter
//  Description : Self-checking bench for sr_iter (directed plus random ops).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_iter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] num;
    logic [4:0]  shamt;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_err    = 0;

    sr_iter u_dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .num    (num),
        .shamt  (shamt),
        .arith  (arith),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] s,
                                          input logic ar);
`ifdef SR_ITER_ARITH_EN
        if (ar) return 32'($signed(a) >>> s);
`endif
        return a >> s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation, scramble the inputs after acceptance, optionally
    // pulse a second start mid-operation, and check latency, busy and result.
    task automatic run_op(input logic [31:0] a, input logic [4:0] s, input logic ar,
                          input bit inject, input string tag);
        logic [31:0] exp;
        int          lat;
        bit          seen;
        bit          busy_ok;
        exp     = model(a, s, ar);
        lat     = -1;
        seen    = 1'b0;
        busy_ok = 1'b1;
        @(negedge clk);
        start = 1'b1; num = a; shamt = s; arith = ar;
        @(negedge clk);
        start = 1'b0; num = $urandom; shamt = 5'($urandom); arith = ~ar;
        for (int i = 0; i <= 40; i++) begin
            if (done) begin
                seen = 1'b1;
                lat  = i;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (inject && i == 5) begin
                start = 1'b1; num = 32'h0; shamt = 5'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"},   32'(lat),  32'(s));
        chk({tag, "_busy_run"},  32'(busy_ok && busy), 32'd1);
        chk({tag, "_result"},    result, exp);
        @(negedge clk);
        chk({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
        chk({tag, "_hold"},       result, exp);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num = '0; shamt = '0; arith = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy",   32'(busy), 32'd0);
        chk("reset_done",   32'(done), 32'd0);
        chk("reset_result", result,    32'd0);
        rst = 1'b0;

        run_op(32'h13579BDF, 5'd2,  1'b0, 1'b0, "srl2");
        run_op(32'hF0000000, 5'd4,  1'b1, 1'b0, "sra4");
        run_op(32'hF0000000, 5'd4,  1'b0, 1'b0, "srl4");
        run_op(32'h11111111, 5'd0,  1'b0, 1'b0, "zero");
        run_op(32'hFFFFFFFF, 5'd31, 1'b0, 1'b1, "srl31_inject");
        run_op(32'h80000000, 5'd31, 1'b1, 1'b0, "sra31");

        // Abort a 10-bit shift three cycles in.
        @(negedge clk);
        start = 1'b1; num = 32'hDEADBEEF; shamt = 5'd10; arith = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy",   32'(busy), 32'd0);
        chk("abort_result", result,    32'd0);
        begin
            bit spurious = 1'b0;
            for (int i = 0; i < 12; i++) begin
                if (done) spurious = 1'b1;
                @(negedge clk);
            end
            chk("abort_no_done", 32'(spurious), 32'd0);
        end
        run_op(32'h00000008, 5'd3, 1'b0, 1'b0, "after_abort");

        for (int t = 0; t < 20; t++) begin
            run_op($urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'b0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
